// File: rtl/ram_read_sequencer.sv
// ram_read_sequencer: decodes memory-read slots from I/T/D and runs a wait-stated RAM read,
// stalling the SC until the word is on the bus. Define RAM_READ_PARITY_EN for read parity checking.
//
// state   | meaning
// IDLE    | waiting for a read slot; a clean request is accepted on the next edge
// WAIT    | RAM access in progress, ram_rd_en high, cnt counts down the wait states
// DONE    | captured word presented to the common bus for one cycle
module ram_read_sequencer #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I,
  input  logic [7:0]        T,
  input  logic [7:0]        D,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic              wr_strobe,
  input  logic [DATA_W-1:0] ram_rdata,
`ifdef RAM_READ_PARITY_EN
  input  logic              ram_rpar,
  output logic              rd_par_err,
`endif
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_sel_mem,
  output logic              rd_done,
  output logic              sc_stall,
  output logic              rd_conflict
);

  if ((READ_LATENCY < 1) || (READ_LATENCY > 15)) begin : g_bad_latency
    $error("ram_read_sequencer: READ_LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        req;
  logic        start;
  logic        rd_en_q;
  logic        unused_decode;

  assign req = T[1] | (~D[7] & I & T[3]) | (D[6] & T[4]) | ((D[0] | D[1] | D[2]) & T[4]);
  assign start = (state == ST_IDLE) & req & ~wr_strobe;
  assign unused_decode = &{1'b0, T[0], T[2], T[7:5], D[5:3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == 4'd1) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address is latched only on acceptance, so AR may move freely while the read is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 4'd0;
      ram_addr    <= '0;
      bus_data    <= '0;
      rd_en_q     <= 1'b0;
      rd_conflict <= 1'b0;
    end else begin
      rd_en_q <= (state_nxt == ST_WAIT);
      if (start) begin
        cnt      <= LAT;
        ram_addr <= ar_addr;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) bus_data <= ram_rdata;
      end
      if ((state == ST_IDLE) && req && wr_strobe) rd_conflict <= 1'b1;
    end
  end

`ifdef RAM_READ_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  par_err_q <= 1'b0;
    else if ((state == ST_WAIT) && (cnt == 4'd1)) par_err_q <= ^{ram_rdata, ram_rpar};
  end

  assign rd_par_err = (state == ST_DONE) & par_err_q;
`endif

  always_comb begin
    ram_rd_en   = rd_en_q;
    rd_done     = (state == ST_DONE);
    bus_sel_mem = (state == ST_DONE);
    sc_stall    = start | (state == ST_WAIT);
  end

endmodule

// File: tb/tb_ram_read_sequencer.sv
// Bench for ram_read_sequencer: latency-2 (a) and latency-1 (b) instances share stimulus and are
// compared every cycle against an elapsed-cycle reference model, plus decode table and corner sequences.
module tb_ram_read_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        I;
  logic [7:0]  T, D;
  logic [11:0] ar_addr;
  logic        wr_strobe;
  logic [15:0] ram_rdata;
  logic        ram_rpar;

  logic        rd_en_a, sel_a, done_a, stall_a, conf_a, perr_a;
  logic [11:0] addr_a;
  logic [15:0] data_a;
  logic        rd_en_b, sel_b, done_b, stall_b, conf_b, perr_b;
  logic [11:0] addr_b;
  logic [15:0] data_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ram_read_sequencer #(.ADDR_W(12), .DATA_W(16), .READ_LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .I(I), .T(T), .D(D), .ar_addr(ar_addr),
    .wr_strobe(wr_strobe), .ram_rdata(ram_rdata),
`ifdef RAM_READ_PARITY_EN
    .ram_rpar(ram_rpar), .rd_par_err(perr_a),
`endif
    .ram_rd_en(rd_en_a), .ram_addr(addr_a), .bus_data(data_a), .bus_sel_mem(sel_a),
    .rd_done(done_a), .sc_stall(stall_a), .rd_conflict(conf_a)
  );

  ram_read_sequencer #(.ADDR_W(12), .DATA_W(16), .READ_LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .I(I), .T(T), .D(D), .ar_addr(ar_addr),
    .wr_strobe(wr_strobe), .ram_rdata(ram_rdata),
`ifdef RAM_READ_PARITY_EN
    .ram_rpar(ram_rpar), .rd_par_err(perr_b),
`endif
    .ram_rd_en(rd_en_b), .ram_addr(addr_b), .bus_data(data_b), .bus_sel_mem(sel_b),
    .rd_done(done_b), .sc_stall(stall_b), .rd_conflict(conf_b)
  );

`ifndef RAM_READ_PARITY_EN
  assign perr_a = 1'b0;
  assign perr_b = 1'b0;
`endif

  // Reference model: k = edges since the read was accepted (0 = no read in flight).
  int          lat[2] = '{2, 1};
  int          k[2];
  logic [11:0] m_addr[2];
  logic [15:0] m_data[2];
  bit          m_conf[2];
  bit          m_perr[2];

  function automatic bit slot_req(bit i, logic [7:0] t, logic [7:0] d);
    return t[1] | (!d[7] & i & t[3]) | (d[6] & t[4]) | ((d[0] | d[1] | d[2]) & t[4]);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      k[n] = 0; m_addr[n] = '0; m_data[n] = '0; m_conf[n] = 0; m_perr[n] = 0;
    end
  endtask

  task automatic model_update();
    bit r;
    r = slot_req(I, T, D);
    for (int n = 0; n < 2; n++) begin
      if (k[n] == 0) begin
        if (r && !wr_strobe) begin
          k[n] = 1;
          m_addr[n] = ar_addr;
        end else if (r && wr_strobe) m_conf[n] = 1;
      end else if (k[n] <= lat[n]) begin
        if (k[n] == lat[n]) begin
          m_data[n] = ram_rdata;
          m_perr[n] = ^{ram_rdata, ram_rpar};
        end
        k[n]++;
      end else k[n] = 0;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic inst_check(int n, string p, logic stall, logic rd_en, logic done, logic sel,
                            logic conf, logic [11:0] addr, logic [15:0] data, logic perr);
    bit busy, fin;
    busy = (k[n] >= 1) && (k[n] <= lat[n]);
    fin  = (k[n] == lat[n] + 1);
    chk({p, "_stall"}, 32'(stall), 32'((k[n] == 0) ? (slot_req(I, T, D) & !wr_strobe) : busy));
    chk({p, "_rd_en"}, 32'(rd_en), 32'(busy));
    chk({p, "_rd_done"}, 32'(done), 32'(fin));
    chk({p, "_bus_sel"}, 32'(sel), 32'(fin));
    chk({p, "_conflict"}, 32'(conf), 32'(m_conf[n]));
    chk({p, "_ram_addr"}, 32'(addr), 32'(m_addr[n]));
    chk({p, "_bus_data"}, 32'(data), 32'(m_data[n]));
`ifdef RAM_READ_PARITY_EN
    chk({p, "_par_err"}, 32'(perr), 32'(fin & m_perr[n]));
`else
    if (perr !== 1'b0) chk({p, "_par_err"}, 32'(perr), 32'd0);
`endif
  endtask

  task automatic sample();
    @(negedge clk);
    inst_check(0, "a", stall_a, rd_en_a, done_a, sel_a, conf_a, addr_a, data_a, perr_a);
    inst_check(1, "b", stall_b, rd_en_b, done_b, sel_b, conf_b, addr_b, data_b, perr_b);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    I = 0; T = '0; D = '0; wr_strobe = 0;
  endtask

  typedef struct {
    bit         i;
    logic [7:0] t;
    logic [7:0] d;
    bit         exp_stall;
  } vec_t;

  vec_t vecs[10];
  int   ndone;

  initial begin
    vecs[0] = '{0, 8'h02, 8'h00, 1};  // fetch T1
    vecs[1] = '{1, 8'h08, 8'h01, 1};  // indirect, D7=0
    vecs[2] = '{0, 8'h08, 8'h01, 0};  // direct, no read
    vecs[3] = '{1, 8'h08, 8'h80, 0};  // D7 register/IO, no read
    vecs[4] = '{0, 8'h10, 8'h04, 1};  // LDA execute
    vecs[5] = '{1, 8'h10, 8'h40, 1};  // ISZ execute
    vecs[6] = '{0, 8'h10, 8'h08, 0};  // STA slot, no read
    vecs[7] = '{0, 8'h20, 8'h02, 0};  // wrong T for ADD
    vecs[8] = '{0, 8'h10, 8'h01, 1};  // AND execute
    vecs[9] = '{1, 8'h01, 8'h00, 0};  // T0 only

    rst_n = 0; idle_inputs(); ar_addr = '0; ram_rdata = '0; ram_rpar = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(stall_a), 0);
    chk("reset_rd_en", 32'(rd_en_a), 0);
    chk("reset_done", 32'(done_a | sel_a), 0);
    chk("reset_addr", 32'(addr_a), 0);
    chk("reset_data", 32'(data_a), 0);
    chk("reset_conflict", 32'(conf_a | conf_b), 0);
    rst_n = 1;

    // Decode table: one slot per entry, then idle long enough for both instances to finish.
    foreach (vecs[v]) begin
      I = vecs[v].i; T = vecs[v].t; D = vecs[v].d; wr_strobe = 0;
      ar_addr = 12'($urandom); ram_rdata = 16'($urandom); ram_rpar = 1'($urandom);
      sample();
      chk($sformatf("tbl%0d_stall_a", v), 32'(stall_a), 32'(vecs[v].exp_stall));
      chk($sformatf("tbl%0d_stall_b", v), 32'(stall_b), 32'(vecs[v].exp_stall));
      advance();
      idle_inputs();
      ndone = 0;
      for (int c = 0; c < 4; c++) begin
        sample();
        if (done_a) ndone++;
        advance();
      end
      chk($sformatf("tbl%0d_reads_a", v), 32'(ndone), 32'(vecs[v].exp_stall));
    end

    // Fetch at latency 2 with T1 held while stalled.
    T = 8'h02; ar_addr = 12'h025; ram_rdata = 16'h7123;
    for (int c = 0; c < 4; c++) begin
      sample();
      chk($sformatf("fetch_stall_c%0d", c + 1), 32'(stall_a), 32'(c < 3));
      chk($sformatf("fetch_rd_en_c%0d", c + 1), 32'(rd_en_a), 32'(c == 1 || c == 2));
      chk($sformatf("fetch_done_c%0d", c + 1), 32'(done_a & sel_a), 32'(c == 3));
      if (c == 1) ar_addr = 12'h3FF;
      advance();
    end
    chk("fetch_addr", 32'(addr_a), 32'h025);
    chk("fetch_data", 32'(data_a), 32'h7123);
    idle_inputs();
    repeat (4) begin sample(); advance(); end

    // Latency 1: LDA rd_done exactly two cycles after request.
    T = 8'h10; D = 8'h04; ram_rdata = 16'h0ABC;
    sample(); chk("lda_req_stall_b", 32'(stall_b), 1); advance();
    sample(); chk("lda_wait_b", 32'(rd_en_b & ~done_b), 1); advance();
    sample(); chk("lda_done_b", 32'(done_b), 1); chk("lda_data_b", 32'(data_b), 32'h0ABC); advance();
    idle_inputs();
    repeat (4) begin sample(); advance(); end

    // Read/write collision: no read, sticky conflict.
    T = 8'h10; D = 8'h40; wr_strobe = 1;
    sample();
    chk("conf_stall", 32'(stall_a), 0);
    chk("conf_rd_en", 32'(rd_en_a), 0);
    advance();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("conf_held", 32'(conf_a & conf_b), 1);
      chk("conf_no_read", 32'(rd_en_a | rd_en_b), 0);
      advance();
    end

    // Reset during the second WAIT cycle.
    T = 8'h02; ar_addr = 12'h155; ram_rdata = 16'h5A5A;
    sample(); advance();
    sample(); advance();
    chk("rst_pre_rd_en", 32'(rd_en_a), 1);
    rst_n = 0; idle_inputs();
    #1;
    chk("rst_mid_outputs", 32'({rd_en_a, done_a, sel_a, stall_a, conf_a}), 0);
    chk("rst_mid_addr_data", 32'({addr_a, data_a}), 0);
    model_reset();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_no_done", 32'(done_a | done_b), 0);
    rst_n = 1;
    @(posedge clk); #1;
    T = 8'h02; ar_addr = 12'h0F0; ram_rdata = 16'hBEEF;
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      sample();
      if (done_a) ndone++;
      advance();
    end
    chk("post_rst_read", 32'(ndone), 1);
    chk("post_rst_data", 32'(data_a), 32'hBEEF);
    idle_inputs();
    repeat (4) begin sample(); advance(); end

`ifdef RAM_READ_PARITY_EN
    for (int p = 0; p < 2; p++) begin
      T = 8'h02; ram_rdata = 16'h0001; ram_rpar = 1'(p);
      for (int c = 0; c < 4; c++) begin
        sample();
        if (c == 3) chk($sformatf("par_err_rpar%0d", p), 32'(perr_a & done_a), 32'(p == 0));
        advance();
      end
      idle_inputs();
      repeat (4) begin sample(); advance(); end
    end
`endif

    // Randomized slots, collisions and AR/RAM data churn.
    for (int c = 0; c < 400; c++) begin
      I = 1'($urandom);
      T = ($urandom_range(0, 9) < 8) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      D = ($urandom_range(0, 9) < 8) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      wr_strobe = ($urandom_range(0, 7) == 0);
      ar_addr = 12'($urandom);
      ram_rdata = 16'($urandom);
      ram_rpar = 1'($urandom);
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
